// File: rtl/eth_loopback_pkg.sv
// Shared types and constants for the Ethernet loopback/address-swap stage.
package eth_loopback_pkg;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_SEND_HDR,
      ST_PASS,
      ST_DROP
   } state_t;

   localparam int          HDR_LEN   = 12;
   localparam logic [47:0] MAC_BCAST = 48'hffff_ffff_ffff;

endpackage

// File: rtl/eth_loopback_swap.sv
// Frame loopback: buffers the 12-byte address header, re-emits it with dst/src swapped, then streams the payload.
// Optional destination filter enabled by defining ETH_LOOPBACK_FILTER_EN.
module eth_loopback_swap
   import eth_loopback_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
   parameter int          COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tuser,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic [COUNT_WIDTH-1:0] frame_count,
   output logic [COUNT_WIDTH-1:0] drop_count
);

   localparam logic [3:0] LAST_IDX = 4'(HDR_LEN - 1);

   state_t                 state_q, state_d;
   logic [3:0]             idx_q, idx_d;
   logic [7:0]             hdr_q [HDR_LEN];
   logic [7:0]             hdr_d [HDR_LEN];
   logic                   hdr_last_q, hdr_last_d;
   logic                   hdr_user_q, hdr_user_d;
   logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
   logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

   logic [47:0]            dst_mac;
   logic                   dst_ok;
   logic [3:0]             swap_idx;

   // The destination bytes are complete long before the 12th byte arrives.
   assign dst_mac = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};

`ifdef ETH_LOOPBACK_FILTER_EN
   assign dst_ok = (dst_mac == LOCAL_MAC) || (dst_mac == MAC_BCAST);
`else
   logic unused_mac;
   assign unused_mac = ^{LOCAL_MAC, MAC_BCAST, dst_mac};
   assign dst_ok     = 1'b1;
`endif

   assign swap_idx = (idx_q < 4'd6) ? idx_q + 4'd6 : idx_q - 4'd6;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_HDR;
         idx_q         <= '0;
         hdr_last_q    <= 1'b0;
         hdr_user_q    <= 1'b0;
         frame_count_q <= '0;
         drop_count_q  <= '0;
         for (int i = 0; i < HDR_LEN; i++) hdr_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         hdr_last_q    <= hdr_last_d;
         hdr_user_q    <= hdr_user_d;
         frame_count_q <= frame_count_d;
         drop_count_q  <= drop_count_d;
         for (int i = 0; i < HDR_LEN; i++) hdr_q[i] <= hdr_d[i];
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      hdr_d         = hdr_q;
      hdr_last_d    = hdr_last_q;
      hdr_user_d    = hdr_user_q;
      frame_count_d = frame_count_q;
      drop_count_d  = drop_count_q;
      case (state_q)
         ST_HDR: begin
            if (s_axis_tvalid) begin
               hdr_d[idx_q] = s_axis_tdata;
               if (idx_q == LAST_IDX) begin
                  idx_d      = '0;
                  hdr_last_d = s_axis_tlast;
                  hdr_user_d = s_axis_tuser;
                  if (dst_ok) begin
                     state_d = ST_SEND_HDR;
                  end else begin
                     drop_count_d = drop_count_q + COUNT_WIDTH'(1);
                     state_d      = s_axis_tlast ? ST_HDR : ST_DROP;
                  end
               end else if (s_axis_tlast) begin
                  // Runt: shorter than the address header.
                  idx_d        = '0;
                  drop_count_d = drop_count_q + COUNT_WIDTH'(1);
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_SEND_HDR: begin
            if (m_axis_tready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = hdr_last_q ? ST_HDR : ST_PASS;
                  if (hdr_last_q) frame_count_d = frame_count_q + COUNT_WIDTH'(1);
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_PASS: begin
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
               state_d       = ST_HDR;
               frame_count_d = frame_count_q + COUNT_WIDTH'(1);
            end
         end
         ST_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase
   end

   // Outputs are forced to their idle values whenever reset is asserted.
   always_comb begin
      s_axis_tready = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_HDR:  s_axis_tready = 1'b1;
            ST_SEND_HDR: begin
               m_axis_tvalid = 1'b1;
               m_axis_tdata  = hdr_q[swap_idx];
               if (idx_q == LAST_IDX) begin
                  m_axis_tlast = hdr_last_q;
                  m_axis_tuser = hdr_user_q;
               end
            end
            ST_PASS: begin
               m_axis_tdata  = s_axis_tdata;
               m_axis_tvalid = s_axis_tvalid;
               m_axis_tlast  = s_axis_tlast;
               m_axis_tuser  = s_axis_tuser & s_axis_tlast;
               s_axis_tready = m_axis_tready;
            end
            ST_DROP: s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
         endcase
      end
   end

   assign frame_count = frame_count_q;
   assign drop_count  = drop_count_q;

endmodule

// File: doc/eth_loopback_swap.md
# eth_loopback_swap

Frame-level loopback stage between the MAC RX FIFO output (`rx_axis_*`) and the MAC TX FIFO input (`tx_axis_*`) of the 1G RGMII MAC-with-FIFO design, in the 125 MHz logic clock domain. It buffers each received frame's 12-byte address header and emits it with destination and source MAC swapped. It then streams the rest of the frame through unchanged. Runt frames are dropped, and frame and drop statistics are kept, so board bring-up needs no host-side echo logic.

## Interface
- `LOCAL_MAC`, default 48'h02_00_00_00_00_01: station address, used only by the filter (see Configuration).
- `COUNT_WIDTH`, default 16: width of the statistics counters.

- `clk`  in  1  logic clock, 125 MHz (PLL CLKOP).
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  8  received frame byte.
- `s_axis_tvalid`  in  1  input byte valid.
- `s_axis_tready`  out  1  input byte accepted.
- `s_axis_tlast`  in  1  last byte of frame.
- `s_axis_tuser`  in  1  bad-frame flag, sampled on the tlast beat.
- `m_axis_tdata`  out  8  looped frame byte.
- `m_axis_tvalid`  out  1  output byte valid.
- `m_axis_tready`  in  1  downstream accepts byte.
- `m_axis_tlast`  out  1  last byte of frame.
- `m_axis_tuser`  out  1  bad-frame flag, on the tlast beat.
- `frame_count`  out  COUNT_WIDTH  frames fully emitted (counted on the output tlast handshake).
- `drop_count`  out  COUNT_WIDTH  frames discarded.

## Operation
- FSM states and transitions:
  - **HDR**: `s_axis_tready`=1. Each accepted byte is written to `hdr[idx]`, idx 0..11.
    - tlast with idx<11 → runt; increment `drop_count`; stay in HDR with idx=0.
    - Accept at idx=11 → latch `hdr_last`=tlast and `hdr_user`=tuser.
      - If the filter rejects the frame: go to DROP, or to HDR if `hdr_last`=1. Increment `drop_count` either way.
      - Otherwise go to SEND_HDR.
  - **SEND_HDR**: `s_axis_tready`=0; `m_axis_tvalid`=1.
    - Output order is `hdr[6..11]` then `hdr[0..5]`, i.e. the source address becomes the destination and vice versa.
    - The index advances only on `m_axis_tvalid && m_axis_tready`.
    - The 12th byte carries `m_axis_tlast`=`hdr_last` and `m_axis_tuser`=`hdr_user`.
    - On the 12th handshake: go to HDR if `hdr_last`, else PASS.
  - **PASS**: combinational pass-through.
    - `m_axis_t{data,valid,last,user}` = `s_axis_*`; `s_axis_tready` = `m_axis_tready`.
    - Handshake with tlast → HDR.
  - **DROP**: `s_axis_tready`=1, `m_axis_tvalid`=0. Handshake with tlast → HDR.
- AXI-stream rules:
  - Once `m_axis_tvalid` is asserted, it and the data stay stable until the handshake.
  - `m_axis_tuser` is meaningful only on tlast beats and is 0 on all other beats.
- Counters wrap modulo 2^COUNT_WIDTH. `frame_count` counts frames with tuser=1 as well.

## Timing
- Reset values:
  - State HDR, idx 0.
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `m_axis_tdata` all 0.
  - `s_axis_tready` is 0 while `rst` is high.
  - Both counters 0.
- Latency:
  - First output byte is valid on the cycle after the 12th input byte is accepted.
  - Payload bytes have zero cycles of latency.
- Throughput: 12 input-stall cycles per frame (during SEND_HDR); line rate is otherwise preserved.
- `m_axis_tready` low during SEND_HDR holds the index; no bytes are lost.
- A 12-byte frame is emitted as exactly 12 bytes, with tlast on byte 12.
- Reset mid-frame returns the block to HDR immediately; any partial output frame is abandoned without tlast. The downstream FIFO is reset by the same `rst`.
- A drop and a frame completion never coincide, because the block processes one frame at a time.

## Configuration
- Macro `ETH_LOOPBACK_FILTER_EN`:
  - **Defined**: a frame is looped only if its destination (`hdr[0..5]`) equals `LOCAL_MAC` or ff:ff:ff:ff:ff:ff. Otherwise it is consumed in DROP and counted in `drop_count`.
  - **Undefined**: every frame of at least 12 bytes is looped. `LOCAL_MAC` is unused, and only runts increment `drop_count`.

## Structure
- Package `eth_loopback_pkg` holds:
  - the state enum (HDR, SEND_HDR, PASS, DROP);
  - `HDR_LEN`=12;
  - `MAC_BCAST`=48'hffff_ffff_ffff.
- Single module with no sub-module. The header buffer is a 12×8 register array inside the block.

## Test plan
- 64-byte frame, dst 02:00:00:00:00:01, src 0a:0b:0c:0d:0e:0f, `m_axis_tready`=1 → output 64 bytes: first 6 are 0a..0f, next 6 are 02:00:00:00:00:01, payload identical, tlast on byte 64, `frame_count`=1.
- 8-byte runt with tlast → no output beats, `drop_count`=1, next frame loops normally.
- Random `m_axis_tready` (50 %) over 100 back-to-back 60–1514-byte frames → byte-exact swapped output, `frame_count`=100, no tvalid drop before a handshake.
- Input tuser=1 on tlast of a 70-byte frame → output tuser=1 on byte 70 only.
- With `ETH_LOOPBACK_FILTER_EN`: dst 02:00:00:00:00:99 → dropped, `drop_count`=1. dst broadcast → looped.
- Assert `rst` at byte 30 of a 100-byte frame → outputs at reset values on the next cycle; a following 64-byte frame loops correctly.
